hdr_field_scheduler: RTL and testbench

HDR_FIELD_SCHEDULER -- requirements
Module: hdr_field_scheduler

---
 rtl/hdr_field_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_hdr_field_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_field_scheduler.sv
// Header-field scheduler: serves per-requester field segments in ascending index order into one field stream.
// Latency: pkt_start to first field on valid_o is 3 cycles; every segment switch costs one SEL bubble.
// Backpressure: a single output register holds while valid_o=1 and hdr_ready_i=0; requesters then see req_ready_o=0.
module hdr_field_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int BIT_CNT_W  = 6,
  parameter int HDR_DATA_W = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pkt_start_i,
  input  logic [NUM_REQ-1:0]              pkt_mask_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ-1:0]              req_last_i,
  input  logic [NUM_REQ-1:0]              req_zero_i,
  input  logic [NUM_REQ-1:0]              req_ones_i,
  input  logic [NUM_REQ*BIT_CNT_W-1:0]    req_bit_cnt_i,
  input  logic [NUM_REQ*HDR_DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic                            valid_o,
  output logic                            hdr_last_o,
  output logic                            insert_zero_o,
  output logic                            insert_ones_o,
  output logic [BIT_CNT_W-1:0]            bit_cnt_o,
  output logic [HDR_DATA_W-1:0]           hdr_data_o,
  input  logic                            hdr_ready_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      pending_q, pending_d;
  logic [GW-1:0]           grant_q, grant_d;

  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    zero_q, zero_d;
  logic                    ones_q, ones_d;
  logic [BIT_CNT_W-1:0]    cnt_q, cnt_d;
  logic [HDR_DATA_W-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  // Granted requester's field, selected from the packed request buses.
  logic                    g_vld;
  logic                    g_last;
  logic                    g_zero;
  logic                    g_ones;
  logic [BIT_CNT_W-1:0]    g_cnt;
  logic [HDR_DATA_W-1:0]   g_data;
  logic [NUM_REQ-1:0]      grant_oh;

  logic [GW-1:0]           sel_idx;
  logic                    out_rdy;
  logic                    in_xfer;
  logic                    accept;
  logic                    bad_fld;
  logic [NUM_REQ-1:0]      pend_clr;
  logic                    pkt_end;

  // Lowest-index pending requester; masked-off requesters are simply never pending.
  always_comb begin
    sel_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pending_q[k]) begin
        sel_idx = GW'(k);
      end
    end
  end

  // Route the granted requester's field onto local signals.
  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
    g_vld             = req_valid_i[grant_q];
    g_last            = req_last_i[grant_q];
    g_zero            = req_zero_i[grant_q];
    g_ones            = req_ones_i[grant_q];
    g_cnt             = req_bit_cnt_i[grant_q*BIT_CNT_W +: BIT_CNT_W];
    g_data            = req_data_i[grant_q*HDR_DATA_W +: HDR_DATA_W];
  end

  // The output register can take a new field when empty or draining this cycle.
  assign out_rdy  = ~valid_q | hdr_ready_i;
  assign in_xfer  = (state_q == XFER);
  assign accept   = in_xfer & g_vld & out_rdy;
  // Oversized counts and contradictory fill flags are flagged but still passed on untouched.
  assign bad_fld  = (32'(g_cnt) > 32'(HDR_DATA_W)) | (g_zero & g_ones);
  assign pend_clr = pending_q & ~grant_oh;
  assign pkt_end  = g_last & (pend_clr == '0);

  // Only the granted requester may see ready, and only while transferring.
  always_comb begin
    req_ready_o = '0;
    if (in_xfer) begin
      req_ready_o[grant_q] = out_rdy;
    end
  end

  // Next-state: FSM, pending set, output register and status flags.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    last_d    = last_q;
    zero_d    = zero_q;
    ones_d    = ones_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = err_q;

    // Output register: load on accept, otherwise drop the beat once taken.
    if (accept) begin
      valid_d = 1'b1;
      last_d  = pkt_end;
      zero_d  = g_zero;
      ones_d  = g_ones;
      cnt_d   = g_cnt;
      data_d  = g_data;
    end else if (hdr_ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pkt_start_i && (pkt_mask_i != '0)) begin
          pending_d = pkt_mask_i;
          err_d     = 1'b0;
          state_d   = SEL;
        end
      end
      SEL: begin
        grant_d = sel_idx;
        state_d = XFER;
      end
      XFER: begin
        if (accept) begin
          if (bad_fld) begin
            err_d = 1'b1;
          end
          if (g_last) begin
            pending_d = pend_clr;
            state_d   = pkt_end ? DONE : SEL;
          end
        end
      end
      DONE: begin
        // Wait for the final beat to be taken before signalling completion.
        if (!valid_q || hdr_ready_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      zero_q    <= 1'b0;
      ones_q    <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      zero_q    <= zero_d;
      ones_q    <= ones_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign valid_o       = valid_q;
  assign hdr_last_o    = last_q;
  assign insert_zero_o = zero_q;
  assign insert_ones_o = ones_q;
  assign bit_cnt_o     = cnt_q;
  assign hdr_data_o    = data_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_hdr_field_scheduler.sv
// Directed bench for hdr_field_scheduler with a scoreboard queue and a decoupled monitor.
// Requester models offer queued fields; expected beats are pushed by hand alongside the stimulus.
// Checks ordering, stall stability, error flag, ignored starts, mid-packet reset and bubble timing.
module tb_hdr_field_scheduler;

  localparam int N  = 4;
  localparam int CW = 6;
  localparam int DW = 32;

  typedef struct packed {
    logic          last;
    logic          zero;
    logic          ones;
    logic [CW-1:0] cnt;
    logic [DW-1:0] data;
  } fld_t;

  typedef struct {
    int          id;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  localparam int C_RST_OUT  = 0;
  localparam int C_DONE_GAP = 1;
  localparam int C_DONE_CNT = 2;
  localparam int C_ERR      = 3;
  localparam int C_BUSY     = 4;
  localparam int C_READY    = 5;
  localparam int C_TIMEOUT  = 6;
  localparam int C_RST_MID  = 7;
  localparam int C_BEAT_T   = 8;
  localparam int C_BEAT_N   = 9;
  localparam int C_DRAIN    = 10;
  localparam int C_VALID    = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic            pkt_start_i;
  logic [N-1:0]    pkt_mask_i;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_last_i;
  logic [N-1:0]    req_zero_i;
  logic [N-1:0]    req_ones_i;
  logic [N*CW-1:0] req_bit_cnt_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_ready_o;
  logic            valid_o;
  logic            hdr_last_o;
  logic            insert_zero_o;
  logic            insert_ones_o;
  logic [CW-1:0]   bit_cnt_o;
  logic [DW-1:0]   hdr_data_o;
  logic            hdr_ready_i;
  logic            busy_o;
  logic            done_o;
  logic            err_o;

  hdr_field_scheduler #(
    .NUM_REQ    (N),
    .BIT_CNT_W  (CW),
    .HDR_DATA_W (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_start_i   (pkt_start_i),
    .pkt_mask_i    (pkt_mask_i),
    .req_valid_i   (req_valid_i),
    .req_last_i    (req_last_i),
    .req_zero_i    (req_zero_i),
    .req_ones_i    (req_ones_i),
    .req_bit_cnt_i (req_bit_cnt_i),
    .req_data_i    (req_data_i),
    .req_ready_o   (req_ready_o),
    .valid_o       (valid_o),
    .hdr_last_o    (hdr_last_o),
    .insert_zero_o (insert_zero_o),
    .insert_ones_o (insert_ones_o),
    .bit_cnt_o     (bit_cnt_o),
    .hdr_data_o    (hdr_data_o),
    .hdr_ready_i   (hdr_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [48:0] all_out;
  assign all_out = {valid_o, hdr_last_o, insert_zero_o, insert_ones_o, busy_o, done_o, err_o,
                    req_ready_o, bit_cnt_o, hdr_data_o};

  fld_t   rq[N][$];
  fld_t   exp_q[$];
  chk_t   chk_q[$];
  int     beat_cyc[$];
  int     n_chk    = 0;
  int     n_fail   = 0;
  int     done_cnt = 0;
  int     done_cyc = 0;
  int     last_cyc = 0;
  int     rdy_mode = 0;
  logic [N-1:0] fire = '0;

  function automatic string chk_name(input int id);
    case (id)
      C_RST_OUT:  return "reset_outputs";
      C_DONE_GAP: return "done_after_last";
      C_DONE_CNT: return "done_pulse_count";
      C_ERR:      return "err_flag";
      C_BUSY:     return "busy";
      C_READY:    return "req_ready";
      C_TIMEOUT:  return "done_timeout";
      C_RST_MID:  return "midpkt_reset_outputs";
      C_BEAT_T:   return "beat_cycle";
      C_BEAT_N:   return "beat_number";
      C_DRAIN:    return "scoreboard_drain";
      C_VALID:    return "valid_before_reset";
      default:    return "unknown";
    endcase
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: resolves queued direct checks, scoreboard beats and stall holds.
  logic stall_q = 1'b0;
  fld_t held;
  always @(negedge clk) begin : mon
    chk_t c;
    fld_t cur;
    fld_t e;
    #2;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      check(chk_name(c.id), c.act, c.exp);
    end
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      cur = {hdr_last_o, insert_zero_o, insert_ones_o, bit_cnt_o, hdr_data_o};
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stall_q) begin
        check("stall_hold", 64'({valid_o, cur}), 64'({1'b1, held}));
      end
      if (valid_o && hdr_ready_i) begin
        if (exp_q.size() == 0) begin
          check("beat_expected", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'(cur), 64'(e));
          if (hdr_last_o) last_cyc = cyc;
          beat_cyc.push_back(cyc);
        end
      end
      stall_q = valid_o && !hdr_ready_i;
      held    = cur;
    end
  end

  task automatic push_chk(input int id, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.id  = id;
    c.act = act;
    c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic add_req(input int k, input logic last, input logic zero, input logic ones,
                         input logic [CW-1:0] cnt, input logic [DW-1:0] data);
    fld_t f;
    f = {last, zero, ones, cnt, data};
    rq[k].push_back(f);
  endtask

  task automatic add_exp(input logic last, input logic zero, input logic ones,
                         input logic [CW-1:0] cnt, input logic [DW-1:0] data);
    fld_t f;
    f = {last, zero, ones, cnt, data};
    exp_q.push_back(f);
  endtask

  // One cycle of requester and sink behaviour, driven on the falling edge.
  task automatic step();
    fld_t f;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (fire[k] && rq[k].size() > 0) void'(rq[k].pop_front());
    end
    pkt_start_i = 1'b0;
    case (rdy_mode)
      0:       hdr_ready_i = 1'b1;
      1:       hdr_ready_i = cyc[0];
      default: hdr_ready_i = 1'b0;
    endcase
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() > 0) begin
        f = rq[k][0];
        req_valid_i[k]             = 1'b1;
        req_last_i[k]              = f.last;
        req_zero_i[k]              = f.zero;
        req_ones_i[k]              = f.ones;
        req_bit_cnt_i[k*CW +: CW]  = f.cnt;
        req_data_i[k*DW +: DW]     = f.data;
      end else begin
        req_valid_i[k] = 1'b0;
        req_last_i[k]  = 1'b0;
        req_zero_i[k]  = 1'b0;
        req_ones_i[k]  = 1'b0;
      end
    end
    #1;
    fire = req_valid_i & req_ready_o;
  endtask

  task automatic start_pkt(input logic [N-1:0] m);
    step();
    pkt_start_i = 1'b1;
    pkt_mask_i  = m;
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int t  = 0;
    while (done_cnt == d0 && t < 200) begin
      step();
      t++;
    end
    push_chk(C_TIMEOUT, 64'(done_cnt != d0), 64'd1);
  endtask

  initial begin
    int d0;
    int base;
    int start_c;
    rst           = 1'b1;
    pkt_start_i   = 1'b0;
    pkt_mask_i    = '0;
    req_valid_i   = '0;
    req_last_i    = '0;
    req_zero_i    = '0;
    req_ones_i    = '0;
    req_bit_cnt_i = '0;
    req_data_i    = '0;
    hdr_ready_i   = 1'b1;

    // Reset: every output low.
    repeat (3) step();
    push_chk(C_RST_OUT, 64'(all_out), 64'd0);
    rst = 1'b0;
    step();

    // Mask 0101: req0 twice then req2; only req2's beat ends the header.
    rdy_mode = 0;
    add_req(0, 1'b0, 1'b0, 1'b0, 6'd8,  32'h0000_00A5);
    add_req(0, 1'b1, 1'b0, 1'b0, 6'd16, 32'h0000_1234);
    add_req(2, 1'b1, 1'b0, 1'b0, 6'd32, 32'hCAFE_F00D);
    add_exp(1'b0, 1'b0, 1'b0, 6'd8,  32'h0000_00A5);
    add_exp(1'b0, 1'b0, 1'b0, 6'd16, 32'h0000_1234);
    add_exp(1'b1, 1'b0, 1'b0, 6'd32, 32'hCAFE_F00D);
    d0 = done_cnt;
    start_pkt(4'b0101);
    wait_done();
    push_chk(C_DONE_GAP, 64'(done_cyc - last_cyc), 64'd1);
    repeat (3) step();
    push_chk(C_DONE_CNT, 64'(done_cnt - d0), 64'd1);
    push_chk(C_ERR, 64'(err_o), 64'd0);

    // Mask 0001 with a toggling sink: 32-bit and zero-length fields pass without error.
    rdy_mode = 1;
    add_req(0, 1'b0, 1'b0, 1'b0, 6'd32, 32'h8000_0001);
    add_req(0, 1'b0, 1'b0, 1'b0, 6'd0,  32'h0000_0007);
    add_req(0, 1'b1, 1'b0, 1'b1, 6'd3,  32'h0000_0005);
    add_exp(1'b0, 1'b0, 1'b0, 6'd32, 32'h8000_0001);
    add_exp(1'b0, 1'b0, 1'b0, 6'd0,  32'h0000_0007);
    add_exp(1'b1, 1'b0, 1'b1, 6'd3,  32'h0000_0005);
    start_pkt(4'b0001);
    wait_done();
    repeat (2) step();
    push_chk(C_ERR, 64'(err_o), 64'd0);

    // Illegal fields: count 33 and zero+ones are forwarded and set the sticky error.
    rdy_mode = 0;
    add_req(0, 1'b0, 1'b0, 1'b0, 6'd33, 32'hDEAD_BEEF);
    add_req(0, 1'b1, 1'b1, 1'b1, 6'd5,  32'h0000_001F);
    add_exp(1'b0, 1'b0, 1'b0, 6'd33, 32'hDEAD_BEEF);
    add_exp(1'b1, 1'b1, 1'b1, 6'd5,  32'h0000_001F);
    start_pkt(4'b0001);
    wait_done();
    repeat (2) step();
    push_chk(C_ERR, 64'(err_o), 64'd1);

    // Start with mask 0 is ignored and leaves the error flag alone.
    step();
    pkt_start_i = 1'b1;
    pkt_mask_i  = 4'b0000;
    repeat (2) step();
    push_chk(C_BUSY, 64'(busy_o), 64'd0);
    push_chk(C_ERR, 64'(err_o), 64'd1);

    // Accepted start clears the error; a start during XFER is ignored.
    start_pkt(4'b0001);
    repeat (2) step();
    push_chk(C_ERR, 64'(err_o), 64'd0);
    push_chk(C_BUSY, 64'(busy_o), 64'd1);
    pkt_start_i = 1'b1;
    pkt_mask_i  = 4'b0010;
    step();
    push_chk(C_BUSY, 64'(busy_o), 64'd1);
    push_chk(C_READY, 64'(req_ready_o), 64'(4'b0001));
    add_req(0, 1'b1, 1'b0, 1'b0, 6'd7, 32'h0000_007F);
    add_exp(1'b1, 1'b0, 1'b0, 6'd7, 32'h0000_007F);
    d0 = done_cnt;
    wait_done();
    repeat (2) step();
    push_chk(C_DONE_CNT, 64'(done_cnt - d0), 64'd1);

    // Reset while a beat is stalled in the output register: everything clears, no done.
    rdy_mode = 2;
    add_req(0, 1'b0, 1'b0, 1'b0, 6'd4, 32'h0000_0011);
    add_req(0, 1'b0, 1'b0, 1'b0, 6'd4, 32'h0000_0022);
    start_pkt(4'b0001);
    repeat (4) step();
    push_chk(C_VALID, 64'(valid_o), 64'd1);
    rst = 1'b1;
    step();
    push_chk(C_RST_MID, 64'(all_out), 64'd0);
    rst = 1'b0;
    rq[0].delete();
    d0 = done_cnt;
    repeat (4) step();
    push_chk(C_DONE_CNT, 64'(done_cnt - d0), 64'd0);

    // All four requesters, one field each: beats every other cycle.
    // Start in cycle c: SEL c+1, accepts at c+2/4/6/8, each visible one cycle later.
    rdy_mode = 0;
    add_req(0, 1'b1, 1'b0, 1'b0, 6'd1, 32'h0000_0101);
    add_req(1, 1'b1, 1'b0, 1'b0, 6'd2, 32'h0000_0202);
    add_req(2, 1'b1, 1'b0, 1'b0, 6'd3, 32'h0000_0303);
    add_req(3, 1'b1, 1'b0, 1'b0, 6'd4, 32'h0000_0404);
    add_exp(1'b0, 1'b0, 1'b0, 6'd1, 32'h0000_0101);
    add_exp(1'b0, 1'b0, 1'b0, 6'd2, 32'h0000_0202);
    add_exp(1'b0, 1'b0, 1'b0, 6'd3, 32'h0000_0303);
    add_exp(1'b1, 1'b0, 1'b0, 6'd4, 32'h0000_0404);
    step();
    base = beat_cyc.size();
    start_pkt(4'b1111);
    start_c = cyc;
    wait_done();
    step();
    push_chk(C_BEAT_N, 64'(beat_cyc.size() - base), 64'd4);
    if (beat_cyc.size() - base >= 4) begin
      for (int i = 0; i < 4; i++) begin
        push_chk(C_BEAT_T, 64'(beat_cyc[base+i] - start_c), 64'(3 + 2*i));
      end
    end

    repeat (3) step();
    push_chk(C_DRAIN, 64'(exp_q.size()), 64'd0);
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
